// File: rtl/reg_bank_v2.sv
// Register bank: NUM_RW write-protected RW registers, W1C event status, IRQ enable, unlock key.
// Optional macro REG_BANK_V2_ERR_EN adds the reg_err pulse output.
module reg_bank_v2 #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 4,
  parameter int NUM_EVT    = 8,
  parameter int UNLOCK_CYC = 16,
  parameter logic [DATA_WIDTH-1:0] RW_RST = 'h1
) (
  input  logic                         reg_clk,
  input  logic                         reg_rstn,
  input  logic                         wp_dis,
  input  logic [NUM_EVT-1:0]           evt_in,
  input  logic                         reg_wr,
  input  logic                         reg_rd,
  input  logic [DATA_WIDTH/8-1:0]      reg_we,
  input  logic [ADDR_WIDTH-1:0]        reg_addr,
  input  logic [DATA_WIDTH-1:0]        reg_wdat,
  output logic [DATA_WIDTH-1:0]        reg_rdat,
  output logic                         reg_rdvld,
  output logic [NUM_RW*DATA_WIDTH-1:0] rw_out,
  output logic                         irq
`ifdef REG_BANK_V2_ERR_EN
  , output logic                       reg_err
`endif
);
  localparam int NB = DATA_WIDTH/8;
  localparam logic [0:0] ST_LOCKED   = 1'b0;
  localparam logic [0:0] ST_UNLOCKED = 1'b1;

  logic [DATA_WIDTH-1:0] rw_q [NUM_RW];
  logic [NUM_EVT-1:0]    status_q, st_clr;
  logic [DATA_WIDTH-1:0] irq_en_q, wmask, rd_mux;
  logic [0:0]            state_q;
  logic [7:0]            cnt_q;
  logic [NUM_RW-1:0]     hit_rw;
  logic                  hit_st, hit_en, hit_key, hit_any;
  logic                  wr_ok, key_wr, key_ok;

  // address decode
  for (genvar i = 0; i < NUM_RW; i++) begin : g_dec
    assign hit_rw[i] = (reg_addr == ADDR_WIDTH'(4*i));
    assign rw_out[i*DATA_WIDTH +: DATA_WIDTH] = rw_q[i];
  end
  assign hit_st  = (reg_addr == ADDR_WIDTH'('h40));
  assign hit_en  = (reg_addr == ADDR_WIDTH'('h44));
  assign hit_key = (reg_addr == ADDR_WIDTH'('h48));
  assign hit_any = (|hit_rw) | hit_st | hit_en | hit_key;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{reg_we[b]}};
  end

  assign wr_ok  = (state_q == ST_UNLOCKED) | wp_dis;
  assign key_wr = reg_wr & hit_key;
  assign key_ok = key_wr & (reg_wdat[15:0] == 16'h5A5A) & (&reg_we);
  assign st_clr = (reg_wr & hit_st) ? (reg_wdat[NUM_EVT-1:0] & wmask[NUM_EVT-1:0]) : '0;

  always_ff @(posedge reg_clk or negedge reg_rstn) begin
    if (!reg_rstn) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= RW_RST;
    end else begin
      for (int i = 0; i < NUM_RW; i++)
        if (reg_wr && hit_rw[i] && wr_ok) rw_q[i] <= (rw_q[i] & ~wmask) | (reg_wdat & wmask);
    end
  end

  // events set after the W1C clear so a same-cycle event survives
  always_ff @(posedge reg_clk or negedge reg_rstn) begin
    if (!reg_rstn) begin
      status_q <= '0;
      irq_en_q <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= (status_q & ~st_clr) | evt_in;
      if (reg_wr && hit_en) irq_en_q <= (irq_en_q & ~wmask) | (reg_wdat & wmask);
      irq <= |(status_q & irq_en_q[NUM_EVT-1:0]);
    end
  end

  // a KEY write always wins over window expiry in the same cycle
  always_ff @(posedge reg_clk or negedge reg_rstn) begin
    if (!reg_rstn) begin
      state_q <= ST_LOCKED;
      cnt_q   <= '0;
    end else if (key_wr) begin
      state_q <= key_ok ? ST_UNLOCKED : ST_LOCKED;
      cnt_q   <= key_ok ? 8'(UNLOCK_CYC) : 8'd0;
    end else if (state_q == ST_UNLOCKED) begin
      if (cnt_q == 8'd1) begin
        state_q <= ST_LOCKED;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_RW; i++) if (hit_rw[i]) rd_mux = rw_q[i];
    if (hit_st)  rd_mux = DATA_WIDTH'(status_q);
    if (hit_en)  rd_mux = irq_en_q;
    if (hit_key) rd_mux = DATA_WIDTH'({cnt_q, state_q});
  end

  always_ff @(posedge reg_clk or negedge reg_rstn) begin
    if (!reg_rstn) begin
      reg_rdat  <= '0;
      reg_rdvld <= 1'b0;
    end else begin
      reg_rdat  <= reg_rd ? rd_mux : '0;
      reg_rdvld <= reg_rd;
    end
  end

`ifdef REG_BANK_V2_ERR_EN
  logic err_d;
  assign err_d = ((reg_wr | reg_rd) & ~hit_any) | (reg_wr & (|hit_rw) & ~wr_ok);
  always_ff @(posedge reg_clk or negedge reg_rstn) begin
    if (!reg_rstn) reg_err <= 1'b0;
    else           reg_err <= err_d;
  end
`else
  // no error reporting: unmapped accesses and blocked writes are dropped silently
  logic unused_hit_any;
  assign unused_hit_any = hit_any;
`endif
endmodule

// File: tb/tb_reg_bank_v2.sv
// Self-checking bench for reg_bank_v2: directed scenarios plus random traffic vs a reference model.
module tb_reg_bank_v2;
  localparam int AW = 24, DW = 32, NRW = 4, NEV = 8, UC = 16;

  logic              reg_clk = 1'b0, reg_rstn = 1'b0, wp_dis = 1'b0;
  logic              reg_wr = 1'b0, reg_rd = 1'b0;
  logic [NEV-1:0]    evt_in = '0;
  logic [DW/8-1:0]   reg_we = '0;
  logic [AW-1:0]     reg_addr = '0;
  logic [DW-1:0]     reg_wdat = '0;
  logic [DW-1:0]     reg_rdat;
  logic              reg_rdvld, irq;
  logic [NRW*DW-1:0] rw_out;
`ifdef REG_BANK_V2_ERR_EN
  logic              reg_err;
`endif

  reg_bank_v2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RW(NRW), .NUM_EVT(NEV),
                .UNLOCK_CYC(UC), .RW_RST(32'h1)) dut (
    .reg_clk(reg_clk), .reg_rstn(reg_rstn), .wp_dis(wp_dis), .evt_in(evt_in),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdat(reg_wdat), .reg_rdat(reg_rdat), .reg_rdvld(reg_rdvld),
    .rw_out(rw_out), .irq(irq)
`ifdef REG_BANK_V2_ERR_EN
    , .reg_err(reg_err)
`endif
  );

  always #5 reg_clk = ~reg_clk;

  int n_cmp = 0, n_bad = 0;

  // reference model: register contents plus the remaining unlock cycles
  logic [DW-1:0]  m_rw [NRW];
  logic [NEV-1:0] m_st;
  logic [DW-1:0]  m_en, m_rdat;
  int             m_left;
  logic           m_irq, m_rdvld, m_err;

  function automatic bit is_rw(input logic [AW-1:0] a);
    return (a < AW'(4*NRW)) && (a[1:0] == 2'b00);
  endfunction

  function automatic bit mapped(input logic [AW-1:0] a);
    return is_rw(a) || a == AW'('h40) || a == AW'('h44) || a == AW'('h48);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (is_rw(a))            return m_rw[int'(a) / 4];
    if (a == AW'('h40))      return DW'(m_st);
    if (a == AW'('h44))      return m_en;
    if (a == AW'('h48))      return DW'(m_left * 2 + (m_left > 0 ? 1 : 0));
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NRW; i++) m_rw[i] = 32'h1;
    m_st = '0; m_en = '0; m_left = 0; m_irq = 0; m_rdat = '0; m_rdvld = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [DW-1:0] mask;
    bit unl;
    for (int b = 0; b < DW/8; b++) mask[b*8 +: 8] = {8{reg_we[b]}};
    unl     = (m_left > 0);
    m_rdat  = reg_rd ? m_read(reg_addr) : '0;
    m_rdvld = reg_rd;
    m_irq   = |(m_st & m_en[NEV-1:0]);
    m_err   = ((reg_wr || reg_rd) && !mapped(reg_addr)) ||
              (reg_wr && is_rw(reg_addr) && !(unl || wp_dis));
    if (reg_wr && is_rw(reg_addr) && (unl || wp_dis))
      m_rw[int'(reg_addr) / 4] = (m_rw[int'(reg_addr) / 4] & ~mask) | (reg_wdat & mask);
    if (reg_wr && reg_addr == AW'('h40)) m_st = m_st & ~(reg_wdat[NEV-1:0] & mask[NEV-1:0]);
    if (reg_wr && reg_addr == AW'('h44)) m_en = (m_en & ~mask) | (reg_wdat & mask);
    m_st = m_st | evt_in;
    if (reg_wr && reg_addr == AW'('h48))
      m_left = (reg_wdat[15:0] == 16'h5A5A && reg_we == 4'hF) ? UC : 0;
    else if (m_left > 0)
      m_left = m_left - 1;
  endtask

  task automatic drv(input bit wr, input bit rd, input logic [3:0] we,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    reg_wr = wr; reg_rd = rd; reg_we = we; reg_addr = a; reg_wdat = d;
  endtask

  task automatic tick();
    model_step();
    @(posedge reg_clk);
    @(negedge reg_clk);
  endtask

  task automatic idle(input int n);
    drv(0, 0, 4'h0, '0, '0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reg_rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge reg_clk);
    n_cmp++; if (reg_rdat !== 32'h0) begin n_bad++; $display("FAIL reset_rdat: got %h want 0", reg_rdat); end
    n_cmp++; if (reg_rdvld !== 1'b0) begin n_bad++; $display("FAIL reset_rdvld: got %b want 0", reg_rdvld); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (rw_out !== {NRW{32'h1}}) begin n_bad++; $display("FAIL reset_rw_out: got %h want %h", rw_out, {NRW{32'h1}}); end
    reg_rstn = 1'b1;
  endtask

  task automatic test_rw_default();
    drv(0, 1, 4'h0, 'h8, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h1 || reg_rdvld !== 1'b1) begin n_bad++; $display("FAIL rw2_read: got %h/%b want 1/1", reg_rdat, reg_rdvld); end
    idle(1);
    n_cmp++; if (reg_rdat !== 32'h0 || reg_rdvld !== 1'b0) begin n_bad++; $display("FAIL idle_read: got %h/%b want 0/0", reg_rdat, reg_rdvld); end
  endtask

  task automatic test_lock();
    wp_dis = 1'b0;
    drv(1, 0, 4'hF, 'h0, 32'hDEAD_BEEF); tick();
    drv(0, 1, 4'h0, 'h0, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h1) begin n_bad++; $display("FAIL locked_write: got %h want 1", reg_rdat); end
    drv(1, 0, 4'hF, 'h48, 32'h5A5A); tick();
    drv(0, 1, 4'h0, 'h48, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h21) begin n_bad++; $display("FAIL key_read: got %h want 21", reg_rdat); end
    drv(1, 0, 4'hF, 'h0, 32'hDEAD_BEEF); tick();
    drv(0, 1, 4'h0, 'h0, '0); tick();
    n_cmp++; if (reg_rdat !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unlocked_write: got %h want deadbeef", reg_rdat); end
    drv(1, 0, 4'hF, 'h48, 32'h0); tick();
    drv(0, 1, 4'h0, 'h48, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h0) begin n_bad++; $display("FAIL bad_key_relock: got %h want 0", reg_rdat); end
  endtask

  task automatic test_window();
    drv(1, 0, 4'hF, 'h48, 32'h5A5A); tick();
    idle(UC);
    drv(1, 0, 4'hF, 'h4, 32'h1234); tick();
`ifdef REG_BANK_V2_ERR_EN
    n_cmp++; if (reg_err !== 1'b1) begin n_bad++; $display("FAIL blocked_err: got %b want 1", reg_err); end
`endif
    drv(0, 1, 4'h0, 'h4, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h1) begin n_bad++; $display("FAIL expired_write: got %h want 1", reg_rdat); end
    drv(1, 0, 4'hF, 'h48, 32'h5A5A); tick();
    idle(UC - 1);
    drv(1, 0, 4'hF, 'h4, 32'h1234); tick();
    drv(0, 1, 4'h0, 'h4, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h1234) begin n_bad++; $display("FAIL last_window_cycle: got %h want 1234", reg_rdat); end
    drv(1, 0, 4'hF, 'h48, 32'h5A5A); tick();
    idle(UC - 1);
    drv(1, 0, 4'hF, 'h48, 32'h5A5A); tick();
    drv(0, 1, 4'h0, 'h48, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h21) begin n_bad++; $display("FAIL rekey_at_expiry: got %h want 21", reg_rdat); end
    drv(1, 0, 4'hF, 'h48, 32'h0); tick();
  endtask

  task automatic test_irq();
    drv(1, 0, 4'hF, 'h44, 32'h8); evt_in = 8'h08; tick();
    evt_in = '0; idle(1);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert: got %b want 1", irq); end
    drv(1, 0, 4'hF, 'h40, 32'h8); evt_in = 8'h08; tick();
    evt_in = '0;
    drv(0, 1, 4'h0, 'h40, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h8) begin n_bad++; $display("FAIL set_beats_clear: got %h want 8", reg_rdat); end
    drv(1, 0, 4'hF, 'h40, 32'h8); tick();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_lag: got %b want 1", irq); end
    idle(1);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_byte_lane();
    wp_dis = 1'b1;
    drv(1, 0, 4'b0010, 'hC, 32'hFFFF_FFFF); tick();
    wp_dis = 1'b0;
    n_cmp++; if (rw_out[3*DW +: DW] !== 32'h0000_FF01) begin n_bad++; $display("FAIL byte_lane: got %h want 0000ff01", rw_out[3*DW +: DW]); end
  endtask

  task automatic test_unmapped();
    drv(0, 1, 4'h0, 'h10, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h0 || reg_rdvld !== 1'b1) begin n_bad++; $display("FAIL unmapped_read: got %h/%b want 0/1", reg_rdat, reg_rdvld); end
`ifdef REG_BANK_V2_ERR_EN
    n_cmp++; if (reg_err !== 1'b1) begin n_bad++; $display("FAIL unmapped_err: got %b want 1", reg_err); end
    idle(1);
    n_cmp++; if (reg_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_end: got %b want 0", reg_err); end
`endif
  endtask

  task automatic test_random();
    logic [AW-1:0] addrs [10] = '{'h0, 'h4, 'h8, 'hC, 'h40, 'h44, 'h48, 'h10, 'h4C, 'h41};
    logic [NRW*DW-1:0] exp_rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0] we;
    for (int c = 0; c < 400; c++) begin
      a  = addrs[$urandom_range(0, 9)];
      d  = $urandom;
      we = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      if (a == AW'('h48) && $urandom_range(0, 1) == 1) d[15:0] = 16'h5A5A;
      drv($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, we, a, d);
      evt_in = ($urandom_range(0, 3) == 0) ? NEV'($urandom) : '0;
      wp_dis = ($urandom_range(0, 15) == 0);
      tick();
      for (int i = 0; i < NRW; i++) exp_rw[i*DW +: DW] = m_rw[i];
      n_cmp++; if (reg_rdat !== m_rdat) begin n_bad++; $display("FAIL rnd_rdat c%0d: got %h want %h", c, reg_rdat, m_rdat); end
      n_cmp++; if (reg_rdvld !== m_rdvld) begin n_bad++; $display("FAIL rnd_rdvld c%0d: got %b want %b", c, reg_rdvld, m_rdvld); end
      n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rnd_irq c%0d: got %b want %b", c, irq, m_irq); end
      n_cmp++; if (rw_out !== exp_rw) begin n_bad++; $display("FAIL rnd_rw_out c%0d: got %h want %h", c, rw_out, exp_rw); end
`ifdef REG_BANK_V2_ERR_EN
      n_cmp++; if (reg_err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, reg_err, m_err); end
`endif
    end
    evt_in = '0; wp_dis = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_window();
    drv(1, 0, 4'hF, 'h48, 32'h5A5A); tick();
    idle(3);
    reg_rstn = 1'b0;
    model_reset();
    evt_in = '1;
    repeat (2) @(negedge reg_clk);
    n_cmp++; if (irq !== 1'b0 || reg_rdvld !== 1'b0) begin n_bad++; $display("FAIL mid_reset_out: got %b/%b want 0/0", irq, reg_rdvld); end
    evt_in = '0;
    reg_rstn = 1'b1;
    drv(0, 1, 4'h0, 'h48, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h0) begin n_bad++; $display("FAIL window_aborted: got %h want 0", reg_rdat); end
    drv(0, 1, 4'h0, 'h40, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h0) begin n_bad++; $display("FAIL evt_in_reset: got %h want 0", reg_rdat); end
    drv(1, 0, 4'hF, 'h0, 32'h55); tick();
    drv(0, 1, 4'h0, 'h0, '0); tick();
    n_cmp++; if (reg_rdat !== 32'h1) begin n_bad++; $display("FAIL post_reset_locked: got %h want 1", reg_rdat); end
  endtask

  initial begin
    @(negedge reg_clk);
    test_reset();
    test_rw_default();
    test_lock();
    test_window();
    test_irq();
    test_byte_lane();
    test_unmapped();
    test_random();
    test_reset_mid_window();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_bank_v2.md
REG_BANK_V2 -- requirements
Module: reg_bank_v2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 24: width of reg_addr.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bus width, multiple of 8, range 16..64.
REQ-003 SHALL have parameter NUM_RW, default 4: number of generic RW registers, range 1..16.
REQ-004 SHALL have parameter NUM_EVT, default 8: number of event/status bits, range 1..DATA_WIDTH.
REQ-005 SHALL have parameter UNLOCK_CYC, default 16: write-unlock window length in cycles, range 1..255.
REQ-006 SHALL have parameter RW_RST, default 'h1: reset value of every RW register.
REQ-007 SHALL have ports: reg_clk in 1, clock; reg_rstn in 1, async active-low reset; one clock, reset asynchronous active-low.
REQ-008 SHALL have ports: wp_dis in 1, 1 = write protection bypassed; evt_in in NUM_EVT, level event sources.
REQ-009 SHALL have ports: reg_wr in 1; reg_rd in 1; reg_we in DATA_WIDTH/8, byte enables; reg_addr in ADDR_WIDTH; reg_wdat in DATA_WIDTH.
REQ-010 SHALL have ports: reg_rdat out DATA_WIDTH; reg_rdvld out 1; rw_out out NUM_RW*DATA_WIDTH, RW register i at slice i; irq out 1.

Function
REQ-011 SHALL decode: RW[i] at 4*i; STATUS at 'h40; IRQ_EN at 'h44; KEY at 'h48; all others unmapped.
REQ-012 SHALL update RW[i] and IRQ_EN bytewise on reg_wr with reg_we[b] set; unset lanes hold.
REQ-013 SHALL clear STATUS bit k on reg_wr with wdat[k]=1 and its lane enabled (W1C); wdat 0 bits hold.
REQ-014 SHALL set STATUS bit k on each cycle evt_in[k]=1; set wins over same-cycle W1C clear.
REQ-015 SHALL register irq = |(STATUS & IRQ_EN[NUM_EVT-1:0]), one cycle after the contributing state changes.
REQ-016 SHALL run lock FSM LOCKED/UNLOCKED: KEY write with wdat[15:0]=16'h5A5A and all lanes enabled -> UNLOCKED, counter = UNLOCK_CYC.
REQ-017 SHALL decrement the counter each UNLOCKED cycle; at 1 -> LOCKED; any other KEY write -> LOCKED immediately; a valid re-key reloads the counter.
REQ-018 SHALL ignore RW[i] writes when LOCKED and wp_dis=0; STATUS/IRQ_EN/KEY writes never blocked.
REQ-019 SHALL return on read: RW[i], STATUS zero-extended, IRQ_EN, KEY reads {0, counter[7:0], unlocked bit0}; unmapped reads 0.
REQ-020 SHALL register reads: reg_rd in cycle N -> reg_rdat valid and reg_rdvld=1 in N+1; otherwise reg_rdat=0, reg_rdvld=0.
REQ-021 SHALL return pre-write value when reg_rd and reg_wr target the same address in the same cycle.
REQ-022 SHALL treat simultaneous reg_wr to KEY while counter expires as KEY write taking priority.

Reset
REQ-023 SHALL on reg_rstn low, asynchronously: RW[i]=RW_RST, STATUS=0, IRQ_EN=0, FSM LOCKED, counter=0, irq=0, reg_rdat=0, reg_rdvld=0.
REQ-024 SHALL abort an open unlock window on reset mid-window; events during reset are not captured.

Configuration
REQ-025 SHALL with REG_BANK_V2_ERR_EN defined add output reg_err (1 bit), pulsed one cycle after any access to an unmapped address or a blocked RW write.
REQ-026 SHALL without REG_BANK_V2_ERR_EN omit reg_err entirely; all other behaviour identical.

Verification
REQ-027 SHALL cover: reset, read RW[2] ('h8) -> next cycle reg_rdat='h1, reg_rdvld=1.
REQ-028 SHALL cover: wp_dis=0, write RW[0]='hDEAD_BEEF without key -> reads 'h1; KEY='h5A5A, then same write -> reads 'hDEAD_BEEF.
REQ-029 SHALL cover: unlock, wait 16 cycles, write RW[1] -> blocked; reg_err pulses if ERR_EN.
REQ-030 SHALL cover: evt_in[3] pulse, IRQ_EN='h8 -> irq=1; W1C 'h8 same cycle as evt_in[3]=1 -> bit stays; next W1C -> irq=0 one cycle later.
REQ-031 SHALL cover: write RW[3] with reg_we='b0010, wdat='hFFFF_FFFF, wp_dis=1 -> RW[3]='h0000_FF01.
